// File: rtl/pwm_pkg.sv
// pwm_pkg -- definitions shared by the PWM generator and the PWM capture block.
//
// Contents:
//   state_e          : measurement FSM states (IDLE, MEAS)
//   CNT_W_DEFAULT    : default counter / result width
//   FILT_LEN_DEFAULT : default glitch-filter length (consecutive samples)
//   sat_value(w)     : all-ones saturation value for a w-bit counter
package pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_e;

   localparam int unsigned CNT_W_DEFAULT    = 16;
   localparam int unsigned FILT_LEN_DEFAULT = 3;

   // Computed in 64 bits so widths up to 63 produce a correct all-ones value
   function automatic longint unsigned sat_value(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync -- brings the asynchronous PWM pin into the clk domain and
// produces single-cycle rise/fall indications.
//
// Build option: PWM_CAPTURE_FILTER_EN
//   undefined : 2-FF synchronizer output drives edge detect directly
//   defined   : a FILT_LEN-sample glitch filter sits between synchronizer and
//               edge detect; level changes only after FILT_LEN consecutive
//               samples disagree with the current filtered level
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   pwm_in : raw asynchronous PWM input
//   level  : synchronized (optionally filtered) PWM level
//   rise   : level is 1 and was 0 the previous cycle
//   fall   : level is 0 and was 1 the previous cycle
module pwm_edge_sync
   import pwm_pkg::*;
`ifdef PWM_CAPTURE_FILTER_EN
#(
   parameter int unsigned FILT_LEN = FILT_LEN_DEFAULT
)
`endif
(
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   // Synchronizer chain and the one-cycle-delayed copy used for edge detect
   always_comb begin
      sync1_d = pwm_in;
      sync2_d = sync1_q;
      prev_d  = level;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);

   logic              filt_q, filt_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   // Count consecutive disagreeing samples; any agreeing sample restarts the
   // count, so pulses shorter than FILT_LEN never reach the edge detector.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (sync2_q != filt_q) begin
         if (fcnt_q == FILT_LAST) begin
            filt_d = sync2_q;
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time (in clk cycles) of a PWM
// waveform, publishing once per PWM cycle, and flags a stalled input.
//
// Build option: PWM_CAPTURE_FILTER_EN enables the input glitch filter
// (FILT_LEN parameter exists only in that build).
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   ena         : 0 forces IDLE and clears counters; results/flags hold
//   pwm_in      : asynchronous PWM input
//   period_out  : cycles between the last two accepted rising edges
//   high_out    : cycles the input was high within that period
//   meas_valid  : one-cycle strobe when period_out/high_out update
//   timeout     : no rising edge for 2^CNT_W-1 cycles; cleared by next rise
//   stuck_level : input level captured when timeout asserted
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
`ifdef PWM_CAPTURE_FILTER_EN
   , parameter int unsigned FILT_LEN = FILT_LEN_DEFAULT
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic level, rise, fall;

   pwm_edge_sync
`ifdef PWM_CAPTURE_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
   u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
   logic [CNT_W-1:0] period_q,  period_d;
   logic [CNT_W-1:0] high_q,    high_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;
   logic             stuck_q,   stuck_d;

   // Measurement FSM. The rise cycle itself counts as the first period and
   // first high cycle, which is why the counters restart at 1 rather than 0.
   // The first rise after IDLE only arms; nothing is published until a
   // complete period has been observed.
   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      stuck_d   = stuck_q;

      if (!ena) begin
         state_d   = IDLE;
         per_cnt_d = '0;
         hi_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               per_cnt_d = '0;
               hi_cnt_d  = '0;
               if (rise) begin
                  state_d   = MEAS;
                  per_cnt_d = CNT_ONE;
                  hi_cnt_d  = CNT_ONE;
                  timeout_d = 1'b0;
               end
            end
            MEAS: begin
               if (rise) begin
                  period_d  = per_cnt_q;
                  high_d    = hi_cnt_q;
                  valid_d   = 1'b1;
                  per_cnt_d = CNT_ONE;
                  hi_cnt_d  = CNT_ONE;
               end else if (per_cnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  stuck_d   = level;
                  state_d   = IDLE;
                  per_cnt_d = '0;
                  hi_cnt_d  = '0;
               end else begin
                  per_cnt_d = per_cnt_q + CNT_ONE;
                  // fall implies level is low; written out so the high counter
                  // visibly stops on the falling edge
                  if (level && !fall && (hi_cnt_q != CNT_MAX)) begin
                     hi_cnt_d = hi_cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               per_cnt_d = '0;
               hi_cnt_d  = '0;
            end
         endcase
      end
   end

   // State, counters and published results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         per_cnt_q <= '0;
         hi_cnt_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         stuck_q   <= stuck_d;
      end
   end

   assign period_out  = period_q;
   assign high_out    = high_q;
   assign meas_valid  = valid_q;
   assign timeout     = timeout_q;
   assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed testbench for pwm_capture.
// Two instances share all inputs: a default-width one (CNT_W=16) and a
// narrow one (CNT_W=4) so timeouts happen within a few dozen cycles.
module tb_pwm_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ena = 1'b1;
   logic        pwm_in = 1'b0;

   logic [15:0] p16, h16;
   logic        v16, t16, s16;
   logic [3:0]  p4, h4;
   logic        v4, t4, s4;

   int checks = 0;
   int errors = 0;

   // strobe statistics gathered on the falling edge, away from the active edge
   int   cyc = 0;
   int   strobes16 = 0;
   int   strobes4 = 0;
   int   doubles = 0;
   int   last_strobe = -1;
   int   space_min = 1000000;
   int   space_max = 0;
   logic prev_v16 = 1'b0;

   pwm_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .pwm_in      (pwm_in),
      .period_out  (p16),
      .high_out    (h16),
      .meas_valid  (v16),
      .timeout     (t16),
      .stuck_level (s16)
   );

   pwm_capture #(.CNT_W(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .pwm_in      (pwm_in),
      .period_out  (p4),
      .high_out    (h4),
      .meas_valid  (v4),
      .timeout     (t4),
      .stuck_level (s4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (v16) begin
         strobes16++;
         if (prev_v16) doubles++;
         if (last_strobe >= 0) begin
            if (cyc - last_strobe < space_min) space_min = cyc - last_strobe;
            if (cyc - last_strobe > space_max) space_max = cyc - last_strobe;
         end
         last_strobe = cyc;
      end
      if (v4) strobes4++;
      prev_v16 = v16;
   end

   task automatic clear_stats();
      strobes16   = 0;
      strobes4    = 0;
      doubles     = 0;
      last_strobe = -1;
      space_min   = 1000000;
      space_max   = 0;
   endtask

   task automatic apply_reset();
      ena    = 1'b1;
      pwm_in = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_stats();
   endtask

   task automatic drive(input logic lvl, input int n);
      repeat (n) begin
         @(posedge clk);
         #1 pwm_in = lvl;
      end
   endtask

   task automatic pwm_periods(input int n, input int per, input int hi);
      repeat (n) begin
         drive(1'b1, hi);
         drive(1'b0, per - hi);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++; if (p16 !== 16'd0) begin errors++; $display("[TB] FAIL reset_period got %0d want 0", p16); end
      checks++; if (h16 !== 16'd0) begin errors++; $display("[TB] FAIL reset_high got %0d want 0", h16); end
      checks++; if (v16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", v16); end
      checks++; if (t16 !== 1'b0 || t4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b/%b want 0/0", t16, t4); end
      checks++; if (s16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stuck got %b want 0", s16); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_stats();
   endtask

   task automatic test_period10();
      apply_reset();
      pwm_periods(1, 10, 3);
      checks++; if (strobes16 != 0) begin errors++; $display("[TB] FAIL p10_first_rise strobes %0d want 0", strobes16); end
      pwm_periods(4, 10, 3);
      drive(1'b0, 4);
      checks++; if (strobes16 != 4) begin errors++; $display("[TB] FAIL p10_strobes got %0d want 4", strobes16); end
      checks++; if (p16 !== 16'd10) begin errors++; $display("[TB] FAIL p10_period got %0d want 10", p16); end
      checks++; if (h16 !== 16'd3) begin errors++; $display("[TB] FAIL p10_high got %0d want 3", h16); end
      checks++; if (space_min != 10 || space_max != 10) begin errors++; $display("[TB] FAIL p10_spacing got %0d..%0d want 10..10", space_min, space_max); end
      checks++; if (p4 !== 4'd10 || h4 !== 4'd3) begin errors++; $display("[TB] FAIL p10_narrow got %0d/%0d want 10/3", p4, h4); end
   endtask

   task automatic test_period2();
      apply_reset();
      pwm_periods(10, 2, 1);
      drive(1'b0, 4);
      checks++; if (strobes16 != 9) begin errors++; $display("[TB] FAIL p2_strobes got %0d want 9", strobes16); end
      checks++; if (p16 !== 16'd2 || h16 !== 16'd1) begin errors++; $display("[TB] FAIL p2_result got %0d/%0d want 2/1", p16, h16); end
      checks++; if (doubles != 0) begin errors++; $display("[TB] FAIL p2_double_valid got %0d want 0", doubles); end
      checks++; if (space_min != 2 || space_max != 2) begin errors++; $display("[TB] FAIL p2_spacing got %0d..%0d want 2..2", space_min, space_max); end
   endtask

   task automatic test_timeout();
      apply_reset();
      pwm_periods(2, 10, 3);
      drive(1'b1, 10);
      checks++; if (t4 !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %b want 0", t4); end
      drive(1'b1, 10);
      checks++; if (t4 !== 1'b1) begin errors++; $display("[TB] FAIL to_flag got %b want 1", t4); end
      checks++; if (s4 !== 1'b1) begin errors++; $display("[TB] FAIL to_stuck got %b want 1", s4); end
      checks++; if (p4 !== 4'd10 || h4 !== 4'd3) begin errors++; $display("[TB] FAIL to_hold got %0d/%0d want 10/3", p4, h4); end
      checks++; if (strobes4 != 2) begin errors++; $display("[TB] FAIL to_strobes got %0d want 2", strobes4); end
      checks++; if (t16 !== 1'b0) begin errors++; $display("[TB] FAIL to_wide got %b want 0", t16); end
      drive(1'b0, 4);
      pwm_periods(1, 8, 4);
      checks++; if (t4 !== 1'b0 || strobes4 != 2) begin errors++; $display("[TB] FAIL to_rearm got timeout %b strobes %0d want 0 2", t4, strobes4); end
      pwm_periods(1, 8, 4);
      drive(1'b0, 4);
      checks++; if (strobes4 != 3) begin errors++; $display("[TB] FAIL to_resume_strobes got %0d want 3", strobes4); end
      checks++; if (p4 !== 4'd8 || h4 !== 4'd4) begin errors++; $display("[TB] FAIL to_resume got %0d/%0d want 8/4", p4, h4); end
   endtask

   task automatic test_idle_ena();
      apply_reset();
      drive(1'b0, 30);
      checks++; if (t4 !== 1'b0) begin errors++; $display("[TB] FAIL idle_timeout got %b want 0", t4); end
      checks++; if (strobes16 != 0 || strobes4 != 0) begin errors++; $display("[TB] FAIL idle_strobes got %0d/%0d want 0/0", strobes16, strobes4); end
      pwm_periods(1, 6, 3);
      @(posedge clk);
      #1 ena = 1'b0;
      repeat (3) @(posedge clk);
      #1 ena = 1'b1;
      pwm_periods(1, 6, 3);
      checks++; if (strobes16 != 0) begin errors++; $display("[TB] FAIL ena_rearm strobes %0d want 0", strobes16); end
      pwm_periods(1, 6, 3);
      drive(1'b0, 3);
      checks++; if (strobes16 != 1) begin errors++; $display("[TB] FAIL ena_publish strobes %0d want 1", strobes16); end
      checks++; if (p16 !== 16'd6 || h16 !== 16'd3) begin errors++; $display("[TB] FAIL ena_result got %0d/%0d want 6/3", p16, h16); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      pwm_periods(2, 10, 3);
      drive(1'b1, 3);
      drive(1'b0, 2);
      checks++; if (p16 !== 16'd10) begin errors++; $display("[TB] FAIL ar_before got %0d want 10", p16); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (p16 !== 16'd0 || h16 !== 16'd0 || v16 !== 1'b0) begin errors++; $display("[TB] FAIL ar_clear got %0d/%0d/%b want 0/0/0", p16, h16, v16); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_stats();
      drive(1'b0, 5);
      checks++; if (strobes16 != 0) begin errors++; $display("[TB] FAIL ar_stray strobes %0d want 0", strobes16); end
      pwm_periods(1, 10, 3);
      checks++; if (strobes16 != 0) begin errors++; $display("[TB] FAIL ar_rearm strobes %0d want 0", strobes16); end
      pwm_periods(1, 10, 3);
      checks++; if (strobes16 != 1 || p16 !== 16'd10 || h16 !== 16'd3) begin errors++; $display("[TB] FAIL ar_publish got %0d strobes %0d/%0d want 1 10/3", strobes16, p16, h16); end
   endtask

   task automatic test_filter();
      int exp_strobes, exp_per, exp_hi, exp_min, exp_max;
`ifdef PWM_CAPTURE_FILTER_EN
      exp_strobes = 3; exp_per = 20; exp_hi = 8; exp_min = 20; exp_max = 20;
`else
      exp_strobes = 6; exp_per = 8;  exp_hi = 2; exp_min = 8;  exp_max = 12;
`endif
      apply_reset();
      repeat (3) begin
         drive(1'b1, 8);
         drive(1'b0, 4);
         drive(1'b1, 2);
         drive(1'b0, 6);
      end
      drive(1'b1, 8);
      drive(1'b0, 6);
      checks++; if (strobes16 != exp_strobes) begin errors++; $display("[TB] FAIL glitch_strobes got %0d want %0d", strobes16, exp_strobes); end
      checks++; if (p16 !== 16'(exp_per) || h16 !== 16'(exp_hi)) begin errors++; $display("[TB] FAIL glitch_result got %0d/%0d want %0d/%0d", p16, h16, exp_per, exp_hi); end
      checks++; if (space_min != exp_min || space_max != exp_max) begin errors++; $display("[TB] FAIL glitch_spacing got %0d..%0d want %0d..%0d", space_min, space_max, exp_min, exp_max); end
   endtask

   initial begin
      test_reset();
      test_period10();
      test_period2();
      test_timeout();
      test_idle_ena();
      test_async_reset();
      test_filter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart to the team's PWM generator.
- Measures an incoming PWM waveform on one pin and reports period and high time in clk cycles.
- Reports a measurement once per PWM cycle with a single-cycle valid strobe.
- Detects a stalled input (0 % or 100 % duty, or a dead line) with a timeout flag.
- Sits inside the tt_um top level; pwm_in comes from a ui_in bit, results are muxed onto uo_out/uio_out.

Parameters:
- CNT_W, 16: width of the period/high counters and result registers.
- FILT_LEN, 3: consecutive equal samples required to accept a level change. Used only with the optional feature.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: 0 = forced to IDLE, counters cleared, no strobes.
- pwm_in, input, 1: asynchronous PWM input.
- period_out, output, CNT_W: cycles between the last two accepted rising edges.
- high_out, output, CNT_W: cycles pwm was high within that period.
- meas_valid, output, 1: one-cycle strobe when period_out/high_out update.
- timeout, output, 1: level; no rising edge for 2^CNT_W-1 cycles.
- stuck_level, output, 1: synchronized pwm level captured when timeout asserted.

Behaviour:
- Input path:
  - 2-FF synchronizer feeds a prev register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Accepted-edge latency: pwm_in sampled high at clk edge N gives rise true during cycle N+2.
- Reset (async, rst_n=0):
  - State = IDLE.
  - All counters = 0.
  - period_out = 0, high_out = 0, meas_valid = 0, timeout = 0, stuck_level = 0.
  - Synchronizer and prev registers = 0.
- States: IDLE, MEAS.
  - IDLE: counters held at 0; rise -> MEAS with per_cnt=1, hi_cnt=1. No publish; the first edge only arms.
  - MEAS, no rise: per_cnt +1 each cycle, saturating at all-ones. hi_cnt +1 while sync=1, held while sync=0, saturating.
  - MEAS, rise: on that clk edge, period_out <= per_cnt and high_out <= hi_cnt, meas_valid=1 the following cycle, per_cnt <= 1, hi_cnt <= 1, stay in MEAS.
  - MEAS, per_cnt reaches all-ones with no rise: timeout <= 1, stuck_level <= sync, state -> IDLE. period_out/high_out keep their last values; no meas_valid.
- timeout clears on the next rise, which re-arms only. The first publish after a timeout needs a second rise.
- Result relations:
  - high_out <= period_out always.
  - high_out = period_out is impossible for a real waveform, because a fall must occur between rises.
- meas_valid is never high for two consecutive cycles. The minimum accepted period is 2 cycles, which gives period_out=2, high_out=1.
- ena=0 mid-measurement: next cycle state = IDLE, counters = 0, meas_valid = 0. Result registers, timeout and stuck_level hold.
- Async reset mid-measurement: everything returns to reset values immediately, with no stray strobe on release.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined: a glitch filter sits between the synchronizer and edge detect.
  - The filtered level changes only after FILT_LEN consecutive synchronized samples differ from it.
  - Accepted-edge latency grows by FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Period measurements are unchanged for clean input because both edges are delayed equally.
- Undefined: the synchronizer output feeds edge detect directly; no filter logic is present.

Decomposition:
- Package pwm_pkg holds:
  - the state enum (IDLE, MEAS);
  - CNT_W default and FILT_LEN default constants, shared with the PWM generator;
  - the all-ones saturation constant as a function of CNT_W.
- One sub-module, pwm_edge_sync: synchronizer, optional filter, prev register, rise/fall outputs.
- Counters and the FSM stay in pwm_capture.

Test Plan:
- Reset, then pwm period 10, high 3, repeated 4 cycles: first rise gives no strobe; each later rise gives meas_valid with period_out=10, high_out=3; strobe spacing exactly 10 clk.
- Period 2, high 1: strobes every 2 cycles, period_out=2, high_out=1, meas_valid never held 2 cycles.
- CNT_W=4, pwm held high after one rise: timeout=1 and stuck_level=1 after per_cnt hits 15; results unchanged; resume period 8 high 4: first rise clears timeout with no strobe, next rise gives 8/4.
- pwm constant 0 from reset, CNT_W=4: remains IDLE, timeout stays 0, no strobe; apply ena=0 mid-MEAS, then 1: no strobe until two fresh rises.
- Assert rst_n low mid-period (per_cnt=5): outputs zero asynchronously, no meas_valid after release, re-arm required.
- With PWM_CAPTURE_FILTER_EN, FILT_LEN=3: 2-cycle glitches inside a period-20, high-8 waveform are ignored, giving period_out=20, high_out=8; without the macro the same stimulus produces extra strobes.
